// File: rtl/alu_pkg.sv
// alu_pkg: opcode/state encodings and range constants shared by the ALU/MDU.
`default_nettype none

package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SRL    = 5'h05,
    OP_SRA    = 5'h06,
    OP_SLL    = 5'h07,
    OP_SLT    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_PASSB  = 5'h0E,
    OP_PASSA  = 5'h0F,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } alu_state_e;

  localparam logic [4:0] M_BASE      = 5'h10;
  localparam logic [4:0] RSV_BASE_LO = 5'h0A;
  localparam logic [4:0] RSV_BASE_HI = 5'h0D;
  localparam logic [4:0] RSV_M_LO    = 5'h18;

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// alu_comb: single-cycle base-op datapath (ADD..PASSA), purely combinational.
`default_nettype none

module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic [4:0]     op_ext;
  logic           rsv;

  assign shamt  = b[SHW-1:0];
  assign op_ext = {1'b0, op};
  assign rsv    = (op_ext >= RSV_BASE_LO) && (op_ext <= RSV_BASE_HI);

  always_comb begin
    y = '0;
    if (!rsv) begin
      case (alu_op_e'(op_ext))
        OP_ADD:   y = a + b;
        OP_SUB:   y = a - b;
        OP_AND:   y = a & b;
        OP_OR:    y = a | b;
        OP_XOR:   y = a ^ b;
        OP_SRL:   y = a >> shamt;
        OP_SRA:   y = $unsigned($signed(a) >>> shamt);
        OP_SLL:   y = a << shamt;
        OP_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        OP_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
        OP_PASSB: y = b;
        OP_PASSA: y = a;
        default:  y = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// alu_mdu: RV32I base ops in one cycle plus RV32M on a shared iterative mul/div engine.
`default_nettype none

module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned AW  = 2 * XLEN + 1;
  localparam logic [SHW-1:0]  LAST_IT  = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      state;
  logic [SHW-1:0]  cnt;
  logic [AW-1:0]   acc;
  logic [XLEN-1:0] opnd;
  logic [2:0]      op_q;
  logic            neg_q;

  // Request decode, evaluated only when accepting in IDLE
  logic            is_m, is_mul, is_div, is_rem;
  logic            a_sgn, b_sgn, sa, sb, div_zero, div_ovf, neg;
  logic [XLEN-1:0] mag_a, mag_b, comb_y, base_y, special_y;

  assign is_m   = (req_op >= M_BASE) && (req_op < RSV_M_LO);
  assign is_mul = is_m && !req_op[2];
  assign is_div = is_m && req_op[2];
  assign is_rem = req_op[1];

  assign a_sgn = (req_op == OP_MUL) || (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                 (req_op == OP_DIV) || (req_op == OP_REM);
  assign b_sgn = (req_op == OP_MUL) || (req_op == OP_MULH) ||
                 (req_op == OP_DIV) || (req_op == OP_REM);
  assign sa    = a_sgn && req_a[XLEN-1];
  assign sb    = b_sgn && req_b[XLEN-1];
  assign mag_a = sa ? -req_a : req_a;
  assign mag_b = sb ? -req_b : req_b;

  assign div_zero  = (req_b == '0);
  assign div_ovf   = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                     (req_a == MOST_NEG) && (req_b == '1);
  assign neg       = (is_div && is_rem) ? sa : (sa ^ sb);
  assign special_y = div_zero ? (is_rem ? req_a : '1) : (is_rem ? '0 : req_a);
  assign base_y    = req_op[4] ? '0 : comb_y;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .op (req_op[3:0]),
    .a  (req_a),
    .b  (req_b),
    .y  (comb_y)
  );

  // One iteration of each engine; acc = {hi(XLEN+1), lo(XLEN)}
  logic [XLEN:0]   mul_sum, rem_sh, rem_new;
  logic            q_bit;
  logic [AW-1:0]   mul_next, div_next;

  assign mul_sum  = acc[AW-1:XLEN] + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {1'b0, mul_sum, acc[XLEN-1:1]};
  assign rem_sh   = acc[AW-2:XLEN-1];
  assign q_bit    = (rem_sh >= {1'b0, opnd});
  assign rem_new  = q_bit ? (rem_sh - {1'b0, opnd}) : rem_sh;
  assign div_next = {rem_new, acc[XLEN-2:0], q_bit};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_y;

  assign prod  = neg_q ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
  assign quo   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rmd   = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_y = !op_q[2] ? ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                          : (op_q[1] ? rmd : quo);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      resp_data <= '0;
    end else if (kill && (state != IDLE)) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op[2:0];
            neg_q <= neg;
            cnt   <= '0;
            if (is_mul) begin
              acc   <= {{(XLEN+1){1'b0}}, mag_b};
              opnd  <= mag_a;
              state <= MUL;
            end else if (is_div && !div_zero && !div_ovf) begin
              acc   <= {{(XLEN+1){1'b0}}, mag_a};
              opnd  <= mag_b;
              state <= DIV;
            end else begin
              resp_data <= is_div ? special_y : base_y;
              state     <= DONE;
            end
          end
        end
        MUL, DIV: begin
          acc <= (state == MUL) ? mul_next : div_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IT) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          resp_data <= fix_y;
          state     <= DONE;
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);

endmodule

`default_nettype wire

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, sequential successor to the single-cycle RV32I ALU. It executes all base integer ops plus the RV32M multiply/divide group behind a valid/ready request/response handshake. Base ops complete in one cycle. MUL*/DIV*/REM* run on a shared iterative shift-add / restoring-divide engine. It sits in the execute stage and stalls the core via `req_ready`/`resp_valid`.

## Interface
- `XLEN`, default 32: operand/result width; power of two, >= 8.
- `SHW`, default $clog2(XLEN): shift-amount width, derived, not overridable.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_op`  in  5  operation code (see Operation).
- `req_a`  in  XLEN  operand A (rs1).
- `req_b`  in  XLEN  operand B (rs2/imm).
- `kill`  in  1  abort the in-flight op; no response is produced.
- `resp_valid`  out  1  result valid; held until accepted.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  XLEN  result.

## Operation
- Op codes 0x00–0x0F (base):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SRL (logical), 6 SRA (arithmetic: sign-fills from `req_a[XLEN-1]`), 7 SLL.
  - 8 SLT, 9 SLTU: result zero-extended, i.e. 0 or 1 in the full XLEN.
  - 0xE PASSB, 0xF PASSA.
  - 0xA–0xD reserved: result 0.
- Op codes 0x10–0x17 (M group):
  - 0x10 MUL (low XLEN), 0x11 MULH (s×s high), 0x12 MULHSU (s×u high), 0x13 MULHU (u×u high).
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
  - 0x18–0x1F reserved: result 0.
- Shifts use `req_b[SHW-1:0]` only. All arithmetic wraps modulo 2^XLEN.
- Multiply method: take operand magnitudes per signedness, form an unsigned 2·XLEN product one bit per cycle (LSB-first shift-add), then negate if the result sign is negative.
- Divide method: restoring divide on magnitudes, one quotient bit per cycle. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Divide special cases are resolved at acceptance and take no iterations:
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a = most-negative, b = −1): DIV result = a; REM result = 0.
- States:
  - IDLE: `req_ready`=1. On accept, go to DONE for base ops, reserved ops and divide special cases. Go to MUL for multiply ops, DIV for divide ops. Operands are latched on accept.
  - MUL / DIV: iteration counter runs 0..XLEN−1. After the last iteration, go to FIX.
  - FIX: apply sign correction and select high/low half or quotient/remainder; go to DONE.
  - DONE: `resp_valid`=1 and `resp_data` is stable. When `resp_ready`=1, go to IDLE.
- `kill` in any state except IDLE: go to IDLE next cycle, `resp_valid`=0, result discarded. `kill` in IDLE has no effect, and a request presented in that same cycle is still accepted.
- `kill` has priority over `resp_ready` in DONE.

## Timing
- Reset (`rst_n`=0 at a clock edge): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, counter=0. Reset mid-iteration discards the op.
- Let the accept edge be N:
  - Base, reserved and divide-special-case ops: `resp_valid` from N+1.
  - Multiply and divide: `resp_valid` from N+XLEN+2 (XLEN iteration cycles + FIX).
- `resp_data` changes only on entry to DONE.
- Max throughput: one base op every 2 cycles (DONE→IDLE→accept). Back-to-back accept with `resp_ready` held high gives responses at N+1, N+3, …
- No combinational path from `req_*` to `resp_*`. `req_ready` is a function of state only.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (5-bit enum of all codes above).
  - `alu_state_e` {IDLE, MUL, DIV, FIX, DONE}.
  - Helper constants for the M-group base (0x10) and the reserved ranges.
- Sub-module `alu_comb`: purely combinational, XLEN-parametrised, base-op datapath (op[3:0] → result). Instantiated once.
- Iterative engine, counter and FSM live in `alu_mdu`. One shared 2·XLEN+1 accumulator serves both MUL and DIV.

## Test plan
- SRA `a`=0x8000_0000, `b`=4 → 0xF800_0000 at N+1. SLT `a`=0xFFFF_FFFF, `b`=1 → 0x0000_0001 exactly.
- MULH `a`=0x8000_0000, `b`=0x8000_0000 → 0x4000_0000. MULHSU `a`=0xFFFF_FFFF, `b`=0xFFFF_FFFF → 0xFFFF_FFFF. Both with `resp_valid` first at N+34.
- DIV `a`=−7, `b`=2 → 0xFFFF_FFFD (−3). REM of the same operands → 0xFFFF_FFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV `a`=5, `b`=0 → 0xFFFF_FFFF and REM → 5, both at N+1. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 and REM → 0, both at N+1.
- MUL accepted, `kill` at N+10 → no `resp_valid`, `req_ready`=1 at N+11. Reset asserted at N+5 of a DIV → all outputs at reset values next cycle.
- Hold `resp_ready`=0 for 5 cycles in DONE → `resp_data` stable, `req_ready`=0. Run the random M/base mix for XLEN=32 and XLEN=16 against a reference model.
